// File: rtl/des_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | des_pkg: shared DES types, permutation tables and byte helper.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package des_pkg;

  // DES numbering: bit 1 is the MSB, so DES bit k of a [N:1] bus sits at index N+1-k.
  typedef logic [64:1] des_block_t;
  typedef logic [32:1] des_half_t;
  typedef logic [8:1]  des_byte_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  localparam int BYTES_PER_BLOCK = 8;

  localparam int IP_TABLE [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TABLE [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  // Byte n holds DES bits 8n+1 .. 8n+8.
  function automatic des_byte_t des_get_byte(input des_block_t blk, input logic [2:0] n);
    des_byte_t b;
    b = '0;
    for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
      if (n == 3'(i)) begin
        b = blk[64 - 8*i -: 8];
      end
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_final_permutation_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | des_final_permutation_tx_if: round-16 input and byte stream bus. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface des_final_permutation_tx_if
  import des_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  des_half_t        l16;
  des_half_t        r16;
  logic             out_valid;
  logic             out_ready;
  des_byte_t        out_byte;
  logic             out_last;
  logic [CNT_W-1:0] blocks_done;

  modport master (
    output in_valid, l16, r16, out_ready,
    input  in_ready, out_valid, out_byte, out_last, blocks_done
  );

  modport slave (
    input  in_valid, l16, r16, out_ready,
    output in_ready, out_valid, out_byte, out_last, blocks_done
  );
endinterface
`default_nettype wire

// File: rtl/des_inverse_permutation.sv
`default_nettype none
// +------------------------------------------------------------------+
// | des_inverse_permutation: combinational IP^-1, preoutput->cipher. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module des_inverse_permutation
  import des_pkg::*;
(
  input  des_block_t i_preout,
  output des_block_t o_cipher
);

  for (genvar gi = 1; gi <= 64; gi++) begin : g_fp
    assign o_cipher[65 - gi] = i_preout[65 - FP_TABLE[gi - 1]];
  end

endmodule
`default_nettype wire

// File: rtl/des_final_permutation_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | des_final_permutation_tx: swap + IP^-1, then 8-byte stream out.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module des_final_permutation_tx
  import des_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  des_final_permutation_tx_if.slave   s_if
);

  tx_state_t        r_state;
  logic [2:0]       r_idx;
  des_block_t       r_blk;
  logic [CNT_W-1:0] r_blocks_done;

  des_block_t       w_preout;
  des_block_t       w_cipher;
  logic             w_send;
  logic             w_last_idx;
  logic             w_in_ready;
  logic             w_accept;
  logic [2:0]       w_sel;

  // The L/R swap happens here: R16 forms the upper half of the preoutput.
  assign w_preout = {s_if.r16, s_if.l16};

  des_inverse_permutation u_fp (
    .i_preout (w_preout),
    .o_cipher (w_cipher)
  );

  assign w_send     = (r_state == ST_SEND);
  assign w_last_idx = (r_idx == 3'd7);
  // Ready during the final byte's handshake lets the next block follow with no bubble.
  assign w_in_ready = !w_send || (w_last_idx && s_if.out_ready);
  assign w_accept   = s_if.in_valid && w_in_ready;
  assign w_sel      = LSB_FIRST ? (3'd7 - r_idx) : r_idx;

  assign s_if.in_ready    = w_in_ready;
  assign s_if.out_valid   = w_send;
  assign s_if.out_last    = w_send && w_last_idx;
  assign s_if.out_byte    = w_send ? des_get_byte(r_blk, w_sel) : '0;
  assign s_if.blocks_done = r_blocks_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= 3'd0;
      r_blk         <= '0;
      r_blocks_done <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_blk   <= w_cipher;
            r_idx   <= 3'd0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (s_if.out_ready) begin
            if (w_last_idx) begin
              r_blocks_done <= r_blocks_done + 1'b1;
              r_idx         <= 3'd0;
              if (w_accept) begin
                r_blk <= w_cipher;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= 3'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_des_final_permutation_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_des_final_permutation_tx: random/directed check vs DES model. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_des_final_permutation_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_done = 0;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [31:0] bl[8];
  logic [31:0] br[8];

  int fp_t[64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
  };

  des_final_permutation_tx_if #(.CNT_W(16)) if0 ();
  des_final_permutation_tx_if #(.CNT_W(2))  if1 ();

  des_final_permutation_tx #(.LSB_FIRST(1'b0), .CNT_W(16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (if0.slave)
  );

  des_final_permutation_tx #(.LSB_FIRST(1'b1), .CNT_W(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (if1.slave)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Ciphertext bit i (1 = MSB) is preoutput bit FP[i]; preoutput is {R16, L16}.
  function automatic logic [63:0] ref_cipher(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] p;
    logic [63:0] c;
    p = {r, l};
    c = '0;
    for (int i = 1; i <= 64; i++) c[64 - i] = p[64 - fp_t[i - 1]];
    return c;
  endfunction

  task automatic push_exp(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] c;
    c = ref_cipher(l, r);
    for (int j = 0; j < 8; j++) q0.push_back(c[63 - 8*j -: 8]);
    for (int j = 7; j >= 0; j--) q1.push_back(c[63 - 8*j -: 8]);
  endtask

  task automatic drive(input logic v, input logic [31:0] l, input logic [31:0] r, input logic ordy);
    if0.in_valid = v;  if0.l16 = l;  if0.r16 = r;  if0.out_ready = ordy;
    if1.in_valid = v;  if1.l16 = l;  if1.r16 = r;  if1.out_ready = ordy;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready0"},  if0.in_ready,  1'b1);
    check({tag, "_in_ready1"},  if1.in_ready,  1'b1);
    check({tag, "_out_valid0"}, if0.out_valid, 1'b0);
    check({tag, "_out_valid1"}, if1.out_valid, 1'b0);
    check({tag, "_out_last0"},  if0.out_last,  1'b0);
    check({tag, "_out_byte0"},  if0.out_byte,  8'h00);
    check({tag, "_out_byte1"},  if1.out_byte,  8'h00);
    check({tag, "_done0"},      if0.blocks_done, 16'd0);
    check({tag, "_done1"},      if1.blocks_done, 2'd0);
  endtask

  // Streams n blocks from bl/br; both DUTs see identical stimulus.
  task automatic run(input int n, input bit rnd);
    int       sent = 0;
    int       got  = 0;
    int       cyc  = 0;
    bit       stall = 1'b0;
    bit       blk_end;
    bit       busy;
    logic     ordy;
    logic [7:0] h0 = '0;
    logic [7:0] h1 = '0;
    while (got < 8*n && cyc < 4000) begin
      ordy = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
      drive(sent < n, (sent < n) ? bl[sent] : 32'h0, (sent < n) ? br[sent] : 32'h0, ordy);
      @(negedge clk);
      busy = (q0.size() > 0);
      check("out_valid0", if0.out_valid, busy);
      check("out_valid1", if1.out_valid, busy);
      check("in_ready0", if0.in_ready, !busy || ((got % 8 == 7) && ordy));
      check("in_ready1", if1.in_ready, !busy || ((got % 8 == 7) && ordy));
      if (stall) begin
        check("stall_hold0", if0.out_byte, h0);
        check("stall_hold1", if1.out_byte, h1);
      end
      stall = if0.out_valid && !ordy;
      h0 = if0.out_byte;
      h1 = if1.out_byte;
      if (if0.in_valid && if0.in_ready) begin
        push_exp(bl[sent], br[sent]);
        sent++;
      end
      blk_end = 1'b0;
      if (if0.out_valid && ordy) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          check("spurious_byte", 1'b1, 1'b0);
        end else begin
          check("byte0", if0.out_byte, q0.pop_front());
          check("byte1", if1.out_byte, q1.pop_front());
        end
        check("last0", if0.out_last, (got % 8) == 7);
        check("last1", if1.out_last, (got % 8) == 7);
        got++;
        if (got % 8 == 0) begin
          exp_done++;
          blk_end = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (blk_end) begin
        check("done0", if0.blocks_done, 64'(exp_done % 65536));
        check("done1", if1.blocks_done, 64'(exp_done % 4));
      end
      cyc++;
    end
    if (got < 8*n) check("timeout", 64'(got), 64'(8*n));
    q0.delete();
    q1.delete();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    int  cnt;
    bit  acc;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset three bytes into a block; the partial block must vanish at once.
    drive(1'b1, 32'h43423234, 32'h0A4CD995, 1'b1);
    cnt = 0;
    for (int c = 0; c < 30 && cnt < 3; c++) begin
      @(negedge clk);
      acc = if0.in_valid && if0.in_ready;
      if (if0.out_valid && if0.out_ready) cnt++;
      @(posedge clk);
      #1;
      if (acc) drive(1'b0, 32'h0, 32'h0, 1'b1);
    end
    check("midrst_bytes", 64'(cnt), 64'd3);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_done = 0;

    bl[0] = 32'h43423234;  br[0] = 32'h0A4CD995;
    run(1, 1'b0);
    bl[0] = 32'h80000000;  br[0] = 32'h00000000;
    run(1, 1'b0);
    bl[0] = 32'h43423234;  br[0] = 32'h0A4CD995;
    run(1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bl[i] = $urandom;  br[i] = $urandom;
    end
    run(2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bl[i] = $urandom;  br[i] = $urandom;
    end
    run(6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
